noc_traffic_node: RTL and testbench
===================================

NOC_TRAFFIC_NODE -- requirements
Module: noc_traffic_node

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  X_ID  0  own X coordinate, Noc_ID_X_Width bits
  Y_ID  0  own Y coordinate, Noc_ID_Y_Width bits
  NOC_X  4  mesh columns
  NOC_Y  4  mesh rows
  FLIT_W  32  flit width; SHALL be >= 2*(Noc_ID_X_Width+Noc_ID_Y_Width)+SEQ_W+2
  SEQ_W  8  packet sequence-number width
  PKT_LEN  4  flits per packet, 1..255
  NUM_PKTS  16  packets per send burst, >= 1
  GAP_CYC  0  idle cycles between packets, 0..255
  DST_MODE  0  0 = fixed destination; 1 = sweep all nodes except self
  DST_X  1  fixed destination X (DST_MODE=0)
  DST_Y  0  fixed destination Y (DST_MODE=0)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  noc_clk  in  1  sole clock; all logic on its rising edge
  noc_rst_n  in  1  reset; synchronous, active-low
  send_start  in  1  begin a burst when sampled high in IDLE
  tx_valid  out  1  flit valid toward router
  tx_ready  in  1  router accepts flit
  tx_flit  out  FLIT_W  outgoing flit
  rx_valid  in  1  flit valid from router
  rx_ready  out  1  node accepts flit
  rx_flit  in  FLIT_W  incoming flit
  send_busy  out  1  burst in progress
  send_done  out  1  burst complete; sticky until next accepted send_start
  rx_pkt_count  out  16  correctly received packets, saturating
  rx_err_count  out  16  detected errors, saturating
  rx_err  out  1  sticky first-error flag

Function
REQ-003 A flit SHALL transfer on a cycle with valid&&ready; while tx_valid=1 and tx_ready=0, tx_flit and tx_valid SHALL hold unchanged.
REQ-004 Flit type field tx_flit[FLIT_W-1:FLIT_W-2]: 01 head, 00 body, 10 tail, 11 single (head+tail, used when PKT_LEN=1).
REQ-005 Head/single payload, LSB first: dst_x, dst_y, src_x (=X_ID), src_y (=Y_ID), seq; other bits zero.
REQ-006 Body/tail payload: bits[7:0] = flit index (1..PKT_LEN-1), next SEQ_W bits = seq; other bits zero.
REQ-007 Generator FSM states SHALL be IDLE, HEAD, BODY, GAP, DONE.
REQ-008 IDLE or DONE with send_start=1 -> HEAD next cycle; tx_valid=1 that cycle (1-cycle latency); send_done clears, send_busy sets; seq and packet counter reset to 0.
REQ-009 HEAD: on transfer -> BODY if PKT_LEN>1, else end-of-packet.
REQ-010 BODY: each transfer increments index; transfer of index PKT_LEN-1 (tail) is end-of-packet.
REQ-011 End-of-packet: seq increments (wraps mod 2^SEQ_W); if NUM_PKTS packets sent -> DONE; else GAP when GAP_CYC>0 (tx_valid=0 for exactly GAP_CYC cycles), else HEAD directly (back-to-back, no bubble).
REQ-012 DONE: send_busy=0, send_done=1, tx_valid=0.
REQ-013 send_start while HEAD/BODY/GAP SHALL be ignored.
REQ-014 DST_MODE=1: destination starts at (0,0), advances row-major (x first, wrapping at NOC_X, then y, wrapping at NOC_Y) after each packet, skipping (X_ID,Y_ID).
REQ-015 rx_ready SHALL be 1 at all times outside reset.
REQ-016 Checker states: EXPECT_HEAD, IN_PKT; captures seq and expected index on head.
REQ-017 Error (rx_err_count +1, rx_err set) SHALL be raised for: head dst != own ID; body/tail in EXPECT_HEAD; head/single in IN_PKT; index or seq mismatch; tail at index != PKT_LEN-1; type 00 at index PKT_LEN-1.
REQ-018 An erroneous head/single in IN_PKT SHALL abandon the current packet and restart capture from that head; any other error SHALL return to EXPECT_HEAD.
REQ-019 Tail or single completing without error SHALL increment rx_pkt_count.
REQ-020 Both counters SHALL saturate at 16'hFFFF.

Reset
REQ-021 On a noc_clk edge with noc_rst_n=0: FSMs to IDLE/EXPECT_HEAD; tx_valid=0, tx_flit=0, send_busy=0, send_done=0, rx_ready=0, counters 0, rx_err=0; mid-burst reset SHALL drop tx_valid the next cycle with no tail sent.

Verification
REQ-022 X_ID=0,Y_ID=0,PKT_LEN=4,NUM_PKTS=2,tx_ready=1, pulse send_start -> 8 flits on consecutive cycles, types 01,00,00,10 per packet, seq 0 then 1, send_done=1 after cycle 9.
REQ-023 Same, tx_ready toggled 1/0 each cycle -> identical flit sequence, each flit held stable while ready=0.
REQ-024 PKT_LEN=1, GAP_CYC=2, NUM_PKTS=3 -> three type-11 flits, exactly 2 idle cycles between them.
REQ-025 DST_MODE=1, NOC_X=2, NOC_Y=2, X_ID=1,Y_ID=0, NUM_PKTS=4 -> destinations (0,0),(0,1),(1,1),(0,0).
REQ-026 Inject valid packet, then body flit without head, then head with wrong dst -> rx_pkt_count=1, rx_err_count=2, rx_err=1.
REQ-027 Assert noc_rst_n=0 for one cycle mid-BODY -> tx_valid=0 next cycle, all outputs at reset values, new send_start restarts with seq 0.

Source files
------------

// File: rtl/noc_traffic_node.sv
// noc_traffic_node: mesh NoC endpoint. It generates bursts of numbered test
// packets toward a fixed or sweeping destination, and checks incoming packets
// addressed to this node for framing, index and sequence errors.
module noc_traffic_node #(
  parameter int unsigned X_ID     = 0,
  parameter int unsigned Y_ID     = 0,
  parameter int unsigned NOC_X    = 4,
  parameter int unsigned NOC_Y    = 4,
  parameter int unsigned FLIT_W   = 32,
  parameter int unsigned SEQ_W    = 8,
  parameter int unsigned PKT_LEN  = 4,
  parameter int unsigned NUM_PKTS = 16,
  parameter int unsigned GAP_CYC  = 0,
  parameter int unsigned DST_MODE = 0,
  parameter int unsigned DST_X    = 1,
  parameter int unsigned DST_Y    = 0
) (
  input  logic              noc_clk,
  input  logic              noc_rst_n,
  input  logic              send_start,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [FLIT_W-1:0] tx_flit,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [FLIT_W-1:0] rx_flit,
  output logic              send_busy,
  output logic              send_done,
  output logic [15:0]       rx_pkt_count,
  output logic [15:0]       rx_err_count,
  output logic              rx_err
);

  localparam int unsigned XW  = (NOC_X > 1) ? $clog2(NOC_X) : 1;
  localparam int unsigned YW  = (NOC_Y > 1) ? $clog2(NOC_Y) : 1;
  localparam int unsigned IDW = XW + YW;

  localparam logic [XW-1:0]  SELF_X    = XW'(X_ID);
  localparam logic [YW-1:0]  SELF_Y    = YW'(Y_ID);
  localparam logic [IDW-1:0] SELF_ID   = {SELF_Y, SELF_X};
  localparam logic [XW-1:0]  MAX_X     = XW'(NOC_X - 1);
  localparam logic [YW-1:0]  MAX_Y     = YW'(NOC_Y - 1);
  localparam logic [IDW-1:0] FIXED_DST = {YW'(DST_Y), XW'(DST_X)};
  localparam logic [7:0]     LAST_IDX  = 8'(PKT_LEN - 1);
  localparam logic [31:0]    LAST_PKT  = 32'(NUM_PKTS - 1);
  localparam logic [7:0]     GAP_LOAD  = 8'(GAP_CYC - 1);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  // ---------------------------------------------------------------------------
  // Generator
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_GAP,
    S_DONE
  } gen_state_t;

  gen_state_t       r_gen_state;
  gen_state_t       w_gen_next;
  logic [7:0]       r_idx;
  logic [SEQ_W-1:0] r_seq;
  logic [31:0]      r_pkt_cnt;
  logic [7:0]       r_gap_cnt;
  logic [IDW-1:0]   r_dst;

  logic             w_xfer;
  logic             w_start;
  logic             w_eop;
  logic [IDW-1:0]   w_dst_step1;
  logic [IDW-1:0]   w_dst_step2;
  logic [IDW-1:0]   w_dst_adv;
  logic [IDW-1:0]   w_dst_first;

  // Row-major advance: x first, wrapping into the next row, then wrap y.
  function automatic logic [IDW-1:0] step_dst(input logic [IDW-1:0] cur);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = cur[XW-1:0];
    y = cur[IDW-1:XW];
    if (x == MAX_X) begin
      x = '0;
      y = (y == MAX_Y) ? '0 : y + 1'b1;
    end else begin
      x = x + 1'b1;
    end
    return {y, x};
  endfunction

  assign w_xfer = tx_valid && tx_ready;

  // Destination sequencing; a single step can land on this node, so a second
  // step is taken to skip over it.
  always_comb begin
    w_dst_step1 = step_dst(r_dst);
    w_dst_step2 = step_dst(w_dst_step1);
    w_dst_adv   = (w_dst_step1 == SELF_ID) ? w_dst_step2 : w_dst_step1;
    w_dst_first = (SELF_ID == '0) ? step_dst('0) : '0;
    if (DST_MODE == 0) begin
      w_dst_adv   = FIXED_DST;
      w_dst_first = FIXED_DST;
    end
  end

  // Generator state register.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) r_gen_state <= S_IDLE;
    else            r_gen_state <= w_gen_next;
  end

  // Generator next-state logic and packet-boundary detection.
  always_comb begin
    w_gen_next = r_gen_state;
    w_start    = 1'b0;
    w_eop      = 1'b0;
    case (r_gen_state)
      S_IDLE, S_DONE: begin
        if (send_start) begin
          w_gen_next = S_HEAD;
          w_start    = 1'b1;
        end
      end
      S_HEAD: begin
        if (w_xfer) begin
          if (PKT_LEN > 1) w_gen_next = S_BODY;
          else             w_eop      = 1'b1;
        end
      end
      S_BODY: begin
        if (w_xfer && (r_idx == LAST_IDX)) w_eop = 1'b1;
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_gen_next = S_HEAD;
      end
      default: w_gen_next = S_IDLE;
    endcase
    if (w_eop) begin
      if (r_pkt_cnt == LAST_PKT) w_gen_next = S_DONE;
      else if (GAP_CYC > 0)      w_gen_next = S_GAP;
      else                       w_gen_next = S_HEAD;
    end
  end

  // Generator datapath: flit index, sequence, packet count, gap timer, dest.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      r_idx     <= '0;
      r_seq     <= '0;
      r_pkt_cnt <= '0;
      r_gap_cnt <= '0;
      r_dst     <= '0;
    end else begin
      if (w_start) begin
        r_seq     <= '0;
        r_pkt_cnt <= '0;
        r_dst     <= w_dst_first;
      end
      if (r_gen_state == S_HEAD && w_xfer) r_idx <= 8'd1;
      if (r_gen_state == S_BODY && w_xfer) r_idx <= r_idx + 8'd1;
      if (w_eop) begin
        r_seq     <= r_seq + 1'b1;
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
        r_gap_cnt <= GAP_LOAD;
        r_dst     <= w_dst_adv;
      end
      if (r_gen_state == S_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 8'd1;
    end
  end

  // Flit formatting and status outputs. Everything is derived from registers
  // that only move on a transfer, so a stalled flit stays stable.
  always_comb begin
    tx_valid  = 1'b0;
    tx_flit   = '0;
    send_busy = 1'b0;
    send_done = 1'b0;
    case (r_gen_state)
      S_HEAD: begin
        tx_valid  = 1'b1;
        send_busy = 1'b1;
        tx_flit[FLIT_W-1 -: 2]        = (PKT_LEN == 1) ? T_SINGLE : T_HEAD;
        tx_flit[2*IDW+SEQ_W-1:0]      = {r_seq, SELF_ID, r_dst};
      end
      S_BODY: begin
        tx_valid  = 1'b1;
        send_busy = 1'b1;
        tx_flit[FLIT_W-1 -: 2]        = (r_idx == LAST_IDX) ? T_TAIL : T_BODY;
        tx_flit[8+SEQ_W-1:0]          = {r_seq, r_idx};
      end
      S_GAP:   send_busy = 1'b1;
      S_DONE:  send_done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  typedef enum logic {
    C_EXPECT_HEAD,
    C_IN_PKT
  } chk_state_t;

  chk_state_t       r_chk_state;
  chk_state_t       w_chk_next;
  logic             r_rx_ready;
  logic [7:0]       r_exp_idx;
  logic [SEQ_W-1:0] r_cap_seq;
  logic [15:0]      r_pkt_count;
  logic [15:0]      r_err_count;
  logic             r_err;

  logic             w_rx_xfer;
  logic [1:0]       w_rx_type;
  logic [IDW-1:0]   w_rx_dst;
  logic [SEQ_W-1:0] w_rx_head_seq;
  logic [7:0]       w_rx_idx;
  logic [SEQ_W-1:0] w_rx_body_seq;
  logic             w_err;
  logic             w_pkt_ok;
  logic             w_capture;
  logic             w_idx_inc;

  assign w_rx_xfer     = rx_valid && r_rx_ready;
  assign w_rx_type     = rx_flit[FLIT_W-1 -: 2];
  assign w_rx_dst      = rx_flit[IDW-1:0];
  assign w_rx_head_seq = rx_flit[2*IDW +: SEQ_W];
  assign w_rx_idx      = rx_flit[7:0];
  assign w_rx_body_seq = rx_flit[8 +: SEQ_W];

  assign rx_ready     = r_rx_ready;
  assign rx_pkt_count = r_pkt_count;
  assign rx_err_count = r_err_count;
  assign rx_err       = r_err;

  // Checker state register.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) r_chk_state <= C_EXPECT_HEAD;
    else            r_chk_state <= w_chk_next;
  end

  // Checker next-state logic and per-flit verdict.
  always_comb begin
    w_chk_next = r_chk_state;
    w_err      = 1'b0;
    w_pkt_ok   = 1'b0;
    w_capture  = 1'b0;
    w_idx_inc  = 1'b0;
    if (w_rx_xfer) begin
      if (w_rx_type == T_HEAD || w_rx_type == T_SINGLE) begin
        if (w_rx_dst != SELF_ID) begin
          w_err      = 1'b1;
          w_chk_next = C_EXPECT_HEAD;
        end else begin
          // A head arriving mid-packet is flagged but still starts a new packet.
          if (r_chk_state == C_IN_PKT) w_err = 1'b1;
          if (w_rx_type == T_HEAD) begin
            w_capture  = 1'b1;
            w_chk_next = C_IN_PKT;
          end else begin
            w_chk_next = C_EXPECT_HEAD;
            if (r_chk_state == C_EXPECT_HEAD) w_pkt_ok = 1'b1;
          end
        end
      end else if (r_chk_state == C_EXPECT_HEAD) begin
        w_err = 1'b1;
      end else if ((w_rx_idx != r_exp_idx) || (w_rx_body_seq != r_cap_seq) ||
                   ((w_rx_type == T_TAIL) != (r_exp_idx == LAST_IDX))) begin
        w_err      = 1'b1;
        w_chk_next = C_EXPECT_HEAD;
      end else if (w_rx_type == T_TAIL) begin
        w_pkt_ok   = 1'b1;
        w_chk_next = C_EXPECT_HEAD;
      end else begin
        w_idx_inc = 1'b1;
      end
    end
  end

  // Checker datapath: captured packet context and saturating statistics.
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      r_rx_ready  <= 1'b0;
      r_exp_idx   <= '0;
      r_cap_seq   <= '0;
      r_pkt_count <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      if (w_capture) begin
        r_exp_idx <= 8'd1;
        r_cap_seq <= w_rx_head_seq;
      end else if (w_idx_inc) begin
        r_exp_idx <= r_exp_idx + 8'd1;
      end
      if (w_pkt_ok && r_pkt_count != '1) r_pkt_count <= r_pkt_count + 16'd1;
      if (w_err) begin
        r_err <= 1'b1;
        if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: two instances (fixed-destination multi-flit
// node, sweeping single-flit node with gaps) checked against flit lists and
// packet-outcome arithmetic built from the packet format rules.
module tb_noc_traffic_node;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Node A: (0,0), 4x4 mesh, 4-flit packets, 2 per burst, fixed dest (1,0)
  logic        a_start, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic        a_busy, a_done, a_rx_err;
  logic [31:0] a_tx_flit, a_rx_flit;
  logic [15:0] a_pkt_cnt, a_err_cnt;

  // Node B: (1,0), 2x2 mesh, single-flit packets, gap 2, 4 per burst, sweep
  logic        b_start, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic        b_busy, b_done, b_rx_err;
  logic [31:0] b_tx_flit, b_rx_flit;
  logic [15:0] b_pkt_cnt, b_err_cnt;

  noc_traffic_node #(
    .X_ID(0), .Y_ID(0), .NOC_X(4), .NOC_Y(4), .FLIT_W(32), .SEQ_W(8),
    .PKT_LEN(4), .NUM_PKTS(2), .GAP_CYC(0), .DST_MODE(0), .DST_X(1), .DST_Y(0)
  ) u_a (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(a_start),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_flit(a_tx_flit),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_flit(a_rx_flit),
    .send_busy(a_busy), .send_done(a_done),
    .rx_pkt_count(a_pkt_cnt), .rx_err_count(a_err_cnt), .rx_err(a_rx_err)
  );

  noc_traffic_node #(
    .X_ID(1), .Y_ID(0), .NOC_X(2), .NOC_Y(2), .FLIT_W(32), .SEQ_W(8),
    .PKT_LEN(1), .NUM_PKTS(4), .GAP_CYC(2), .DST_MODE(1), .DST_X(1), .DST_Y(0)
  ) u_b (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(b_start),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_flit(b_tx_flit),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_flit(b_rx_flit),
    .send_busy(b_busy), .send_done(b_done),
    .rx_pkt_count(b_pkt_cnt), .rx_err_count(b_err_cnt), .rx_err(b_rx_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Head/single: type in [31:30]; dst_x, dst_y, src_x, src_y, seq from bit 0 up.
  function automatic logic [31:0] mk_head(int typ, int dx, int dy, int sx, int sy, int seq, int w);
    return (32'(typ) << 30) | 32'(dx) | (32'(dy) << w) | (32'(sx) << (2*w)) |
           (32'(sy) << (3*w)) | (32'(seq) << (4*w));
  endfunction

  // Body/tail: type in [31:30]; index in [7:0]; seq in [15:8].
  function automatic logic [31:0] mk_body(int typ, int idx, int seq);
    return (32'(typ) << 30) | 32'(idx) | (32'(seq) << 8);
  endfunction

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          b_xfer_cyc[$];

  // A: every accepted flit must be the next one in the expected list, and a
  // stalled flit must be held.
  logic        a_pv = 1'b0, a_pr = 1'b0, a_prst = 1'b0;
  logic [31:0] a_pf = '0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (a_tx_valid && a_tx_ready) begin
      e = (qa.size() > 0) ? qa.pop_front() : 32'hFFFF_FFFF;
      check("a_flit", a_tx_flit, e);
    end
    if (a_pv && !a_pr && a_prst) begin
      check("a_hold_valid", a_tx_valid, 1);
      check("a_hold_flit", a_tx_flit, a_pf);
    end
    a_pv = a_tx_valid; a_pr = a_tx_ready; a_pf = a_tx_flit; a_prst = rst_n;
  end

  // B: expected flit order plus the cycle of each transfer.
  always @(negedge clk) begin
    logic [31:0] e;
    if (b_tx_valid && b_tx_ready) begin
      e = (qb.size() > 0) ? qb.pop_front() : 32'hFFFF_FFFF;
      check("b_flit", b_tx_flit, e);
      b_xfer_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mode 0: ready held high; 1: ready toggles; 2: random ready plus a
  // send_start pulse mid-burst that must be ignored.
  task automatic run_burst_a(input int mode, input string tag);
    int cycles;
    qa.delete();
    for (int p = 0; p < 2; p++) begin
      qa.push_back(mk_head(1, 1, 0, 0, 0, p, 2));
      for (int i = 1; i < 4; i++) qa.push_back(mk_body((i == 3) ? 2 : 0, i, p));
    end
    a_tx_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check({tag, "_latency_valid"}, a_tx_valid, 1);
    check({tag, "_busy"}, a_busy, 1);
    check({tag, "_done_clr"}, a_done, 0);
    cycles = 0;
    while (!a_done && cycles < 200) begin
      if (mode == 1) a_tx_ready = ~a_tx_ready;
      else if (mode == 2) a_tx_ready = 1'($urandom_range(0, 1));
      a_start = (mode == 2 && cycles == 5);
      tick();
      cycles++;
    end
    a_start = 1'b0;
    a_tx_ready = 1'b1;
    check({tag, "_done"}, a_done, 1);
    check({tag, "_busy_end"}, a_busy, 0);
    check({tag, "_valid_end"}, a_tx_valid, 0);
    check({tag, "_left"}, 32'(qa.size()), 0);
    if (mode == 0) check({tag, "_cycles"}, 32'(cycles), 8);
  endtask

  task automatic send_rx(input logic [31:0] f);
    repeat ($urandom_range(0, 2)) tick();
    a_rx_valid = 1'b1;
    a_rx_flit  = f;
    tick();
    a_rx_valid = 1'b0;
    a_rx_flit  = $urandom;
  endtask

  task automatic send_pkt(input int s);
    send_rx(mk_head(1, 0, 0, 3, 3, s, 2));
    send_rx(mk_body(0, 1, s));
    send_rx(mk_body(0, 2, s));
    send_rx(mk_body(2, 3, s));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ep, ee, start_cyc, kind, s, k;
    int dl_x[$];
    int dl_y[$];
    rst_n = 1'b0;
    a_start = 0; a_tx_ready = 1; a_rx_valid = 0; a_rx_flit = '0;
    b_start = 0; b_tx_ready = 1; b_rx_valid = 0; b_rx_flit = '0;
    repeat (3) tick();

    check("rst_tx_valid", a_tx_valid, 0);
    check("rst_tx_flit", a_tx_flit, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rx_ready", a_rx_ready, 0);
    check("rst_pkt_cnt", a_pkt_cnt, 0);
    check("rst_err_cnt", a_err_cnt, 0);
    check("rst_rx_err", a_rx_err, 0);
    check("rst_b_valid", b_tx_valid, 0);

    rst_n = 1'b1;
    tick();
    check("rx_ready_a", a_rx_ready, 1);
    check("rx_ready_b", b_rx_ready, 1);

    run_burst_a(0, "burst_ready");
    run_burst_a(1, "burst_toggle");
    run_burst_a(2, "burst_random");

    // B: destination list is every node in row-major order except (1,0).
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++)
        if (!(x == 1 && y == 0)) begin dl_x.push_back(x); dl_y.push_back(y); end
    for (int p = 0; p < 4; p++)
      qb.push_back(mk_head(3, dl_x[p % 3], dl_y[p % 3], 1, 0, p, 1));
    b_xfer_cyc.delete();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    start_cyc = cyc;
    k = 0;
    while (!b_done && k < 200) begin tick(); k++; end
    check("b_done", b_done, 1);
    check("b_left", 32'(qb.size()), 0);
    check("b_xfers", 32'(b_xfer_cyc.size()), 4);
    if (b_xfer_cyc.size() == 4) begin
      check("b_first_lat", 32'(b_xfer_cyc[0] - start_cyc), 0);
      for (int i = 1; i < 4; i++)
        check("b_gap", 32'(b_xfer_cyc[i] - b_xfer_cyc[i-1]), 3);
    end

    // Reset in the middle of A's first packet body.
    qa.delete();
    for (int i = 0; i < 3; i++) qa.push_back((i == 0) ? mk_head(1, 1, 0, 0, 0, 0, 2) : mk_body(0, i, 0));
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    check("mid_busy", a_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_tx_valid", a_tx_valid, 0);
    check("mrst_tx_flit", a_tx_flit, 0);
    check("mrst_busy", a_busy, 0);
    check("mrst_done", a_done, 0);
    check("mrst_rx_ready", a_rx_ready, 0);
    check("mrst_err_cnt", a_err_cnt, 0);
    qa.delete();
    tick();
    check("mrst_valid_stays", a_tx_valid, 0);
    run_burst_a(0, "burst_after_rst");

    // Directed: good packet, stray body, head for another node.
    send_pkt(5);
    send_rx(mk_body(0, 1, 9));
    send_rx(mk_head(1, 1, 0, 3, 3, 6, 2));
    tick();
    check("dir_pkt_cnt", a_pkt_cnt, 1);
    check("dir_err_cnt", a_err_cnt, 2);
    check("dir_rx_err", a_rx_err, 1);

    // Random packet-level scenarios; each leaves the checker awaiting a head.
    ep = 1; ee = 2;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 8);
      s = $urandom_range(0, 255);
      case (kind)
        0: begin send_pkt(s); ep++; end
        1: begin send_rx(mk_body(2 * $urandom_range(0, 1), $urandom_range(0, 3), s)); ee++; end
        2: begin
          send_rx(mk_head($urandom_range(0, 1) ? 3 : 1, $urandom_range(0, 3),
                          $urandom_range(1, 3), 2, 2, s, 2));
          ee++;
        end
        3: begin
          k = $urandom_range(1, 3);
          send_rx(mk_head(1, 0, 0, 1, 1, s, 2));
          for (int i = 1; i < k; i++) send_rx(mk_body(0, i, s));
          send_rx(mk_body((k == 3) ? 2 : 0, k, (s + 1) % 256));
          ee++;
        end
        4: begin
          send_rx(mk_head(1, 0, 0, 1, 1, s, 2));
          send_rx(mk_body(0, 1, s));
          send_pkt((s + 7) % 256);
          ee++; ep++;
        end
        5: begin
          send_rx(mk_head(1, 0, 0, 1, 1, s, 2));
          send_rx(mk_body(0, 1, s));
          send_rx(mk_body(2, 2, s));
          ee++;
        end
        6: begin
          send_rx(mk_head(1, 0, 0, 1, 1, s, 2));
          send_rx(mk_body(0, 1, s));
          send_rx(mk_body(0, 2, s));
          send_rx(mk_body(0, 3, s));
          ee++;
        end
        7: begin send_rx(mk_head(3, 0, 0, 1, 1, s, 2)); ep++; end
        default: begin
          send_rx(mk_head(1, 0, 0, 1, 1, s, 2));
          send_rx(mk_body(0, 2, s));
          ee++;
        end
      endcase
    end
    tick();
    check("rnd_pkt_cnt", a_pkt_cnt, 32'(ep));
    check("rnd_err_cnt", a_err_cnt, 32'(ee));
    check("rnd_rx_err", a_rx_err, 1);
    check("rnd_rx_ready", a_rx_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
